rx_byte_fifo: RTL and testbench
===============================

RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the FIFO entry count; it SHALL be a power of two in 2..16.
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the data byte width.
REQ-003 The block SHALL have port src_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port rx_data, input, WIDTH bits: the received byte from the UART receiver, held stable after its frame ends.
REQ-006 The block SHALL have port rx_bussy, input, 1 bit: the receiver busy flag, asynchronous to src_clk.
REQ-007 The block SHALL have port pop, input, 1 bit: the consumer accepts rd_data this cycle.
REQ-008 The block SHALL have port rd_data, output, WIDTH bits: the head entry (show-ahead).
REQ-009 The block SHALL have port rd_valid, output, 1 bit: the FIFO is not empty.
REQ-010 The block SHALL have port full, output, 1 bit: count equals DEPTH.
REQ-011 The block SHALL have port count, output, clog2(DEPTH)+1 bits: the current occupancy.
REQ-012 The block SHALL have port overflow, output, 1 bit: a sticky flag meaning a byte was dropped.
REQ-013 The block SHALL have port drop_count, output, 8 bits: the number of dropped bytes, saturating.

Function
REQ-014 rx_bussy SHALL pass through a 2-flop synchronizer.
REQ-015 rx_data SHALL be captured into a holding register on the same cycle the synchronized busy is sampled.
REQ-016 The capture FSM SHALL have three states:
- IDLE: synchronized busy=1 -> RECV.
- RECV: synchronized busy=0 -> COMMIT.
- COMMIT: issue one write strobe -> IDLE.
REQ-017 Exactly one write SHALL occur per busy high->low sequence; a busy-low level alone SHALL never write.
REQ-018 Latency: rx_bussy falling at cycle N SHALL make rd_valid=1 and rd_data=byte at cycle N+4, under single-edge synchronizer timing.
REQ-019 rd_data SHALL equal mem[rd_ptr] combinationally; when rd_valid=0 its value is don't-care.
REQ-020 pop with rd_valid=0 SHALL be ignored; pointers, count and flags are unchanged.
REQ-021 A write with full=0 SHALL store to mem[wr_ptr] and increment wr_ptr modulo DEPTH.
REQ-022 A write with full=1 and pop=0 SHALL drop the byte, set overflow, and increment drop_count unless it is at 255.
REQ-023 A write with full=1 and pop=1 SHALL accept both operations; count stays DEPTH and no drop occurs.
REQ-024 Simultaneous write and pop when empty SHALL perform the write only; the pop is ignored per REQ-020.
REQ-025 count SHALL change by +1, -1 or 0 per cycle and SHALL never exceed DEPTH.
REQ-026 overflow SHALL clear only on rst.

Reset
REQ-027 rst SHALL set the following on the next src_clk edge:
- FSM to IDLE;
- wr_ptr, rd_ptr and count to 0;
- rd_valid, full and overflow to 0;
- drop_count to 0;
- synchronizer flops to 0.
REQ-028 rst during RECV SHALL abandon the frame: no write, and a fresh busy rising edge is required before the next commit.
REQ-029 Memory contents SHALL NOT require reset.

Configuration
REQ-030 With macro RX_FIFO_DROP_STATS_EN defined, drop_count SHALL be implemented as specified.
REQ-031 With RX_FIFO_DROP_STATS_EN undefined, drop_count SHALL be tied to 0 and its register omitted; overflow SHALL remain implemented.

Structure
REQ-032 The FSM state encodings (IDLE, RECV, COMMIT) and the default DEPTH/WIDTH constants SHALL reside in the shared common include file.
REQ-033 The 2-flop synchronizer SHALL be a sub-module named sync_2ff; storage and pointers SHALL stay inline.

Verification
REQ-034 After rst, one busy pulse with rx_data=0x41 -> at N+4 rd_valid=1, rd_data=0x41, count=1; after pop, rd_valid=0, count=0.
REQ-035 Push 0x01..0x08 with no pops -> full=1, count=8; popping 8 times returns 0x01..0x08 in order, then rd_valid=0.
REQ-036 Full FIFO plus 3 more frames, no pop -> overflow=1, drop_count=3, contents still 0x01..0x08.
REQ-037 Full FIFO with a commit coincident with pop -> count stays 8, the new byte is last out, overflow=0.
REQ-038 rst asserted while FSM is in RECV, then busy falls -> no write, count=0; the next full busy pulse writes normally.
REQ-039 Stats disabled build: 300 overflow drops -> drop_count=0, overflow=1; stats enabled build: the same stimulus -> drop_count=255 (saturated).

Source files
------------

// File: rtl/rx_byte_fifo_pkg.sv
// Shared constants for the UART receive byte FIFO: default geometry and
// capture FSM state encodings.
package rx_byte_fifo_pkg;

  localparam int unsigned DEF_DEPTH = 8;
  localparam int unsigned DEF_WIDTH = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RECV   = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

endpackage

// File: rtl/rx_byte_fifo_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the local clock.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive byte FIFO: commits one UART byte per busy high->low sequence into a
// show-ahead FIFO. Define RX_FIFO_DROP_STATS_EN to implement drop_count.
module rx_byte_fifo
  import rx_byte_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                   src_clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       rx_data,
  input  logic                   rx_bussy,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_valid,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic             busy_s;
  logic [1:0]       settle;
  logic             armed;
  logic [1:0]       state;
  logic [WIDTH-1:0] hold;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             pop_ok;
  logic             wr_ok;
  logic             is_full;

  sync_2ff u_sync (
    .clk (src_clk),
    .rst (rst),
    .d   (rx_bussy),
    .q   (busy_s)
  );

  // The synchronizer output is only trusted once both flops hold real samples;
  // a frame may start only after busy has been seen low, so a busy level that
  // straddles reset can never produce a commit.
  always_ff @(posedge src_clk) begin
    if (rst) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      if (state == ST_IDLE && settle[1] && !busy_s)
        armed <= 1'b1;
      else if (state == ST_IDLE && armed && busy_s)
        armed <= 1'b0;
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (armed && busy_s) state <= ST_RECV;
        ST_RECV:   if (!busy_s) state <= ST_COMMIT;
        ST_COMMIT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge src_clk) begin
    if (state == ST_RECV && !busy_s)
      hold <= rx_data;
  end

  always_comb begin
    wr_en   = (state == ST_COMMIT);
    is_full = (count == CW'(DEPTH));
    pop_ok  = pop && (count != '0);
    // When full, the same-cycle pop frees the head slot, which is the one wr_ptr points at.
    wr_ok   = wr_en && (!is_full || pop_ok);
  end

  always_ff @(posedge src_clk) begin
    if (wr_ok)
      mem[wr_ptr] <= hold;
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_en && !wr_ok)
        overflow <= 1'b1;
    end
  end

`ifdef RX_FIFO_DROP_STATS_EN
  always_ff @(posedge src_clk) begin
    if (rst)
      drop_count <= '0;
    else if (wr_en && !wr_ok && drop_count != '1)
      drop_count <= drop_count + 1'b1;
  end
`else
  assign drop_count = '0;
`endif

  assign rd_data  = mem[rd_ptr];
  assign rd_valid = (count != '0);
  assign full     = is_full;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Randomized scoreboard bench for rx_byte_fifo against a queue-based reference.
module tb_rx_byte_fifo;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;

  logic             src_clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] rx_data;
  logic             rx_bussy;
  logic             pop;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             full;
  logic [3:0]       count;
  logic             overflow;
  logic [7:0]       drop_count;

  rx_byte_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .src_clk    (src_clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_bussy   (rx_bussy),
    .pop        (pop),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 src_clk = ~src_clk;

  typedef struct {
    int unsigned t;
    logic [7:0]  b;
  } pend_t;

  pend_t       pend[$];
  logic [7:0]  mq[$];
  int unsigned cyc = 0;
  bit          ovf = 0;
  int          drops = 0;
  bit          mon_en = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  // Reference: a committed byte lands exactly four edges after busy is released.
  always @(posedge src_clk) begin
    pend_t p;
    cyc++;
    if (rst) begin
      mq.delete();
      pend.delete();
      ovf   = 0;
      drops = 0;
    end else begin
      if (pop && mq.size() > 0)
        void'(mq.pop_front());
      if (pend.size() > 0 && pend[0].t == cyc) begin
        p = pend.pop_front();
        if (mq.size() < DEPTH) begin
          mq.push_back(p.b);
        end else begin
          ovf = 1;
          if (drops < 255) drops++;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    else
      n_pass++;
  endtask

  always @(negedge src_clk) begin
    int exp_drops;
`ifdef RX_FIFO_DROP_STATS_EN
    exp_drops = drops;
`else
    exp_drops = 0;
`endif
    if (mon_en) begin
      chk("rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
      chk("count", 32'(count), 32'(mq.size()));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(ovf));
      chk("drop_count", 32'(drop_count), 32'(exp_drops));
      if (pop && mq.size() > 0)
        chk("rd_data", 32'(rd_data), 32'(mq[0]));
    end
  end

  task automatic tick();
    @(posedge src_clk);
    #1;
  endtask

  function automatic logic pick_pop(input int mode);
    case (mode)
      1:       return ($urandom_range(0, 11) == 0);
      3:       return ($urandom_range(0, 1) == 1);
      default: return 1'b0;
    endcase
  endfunction

  // mode: 0 no pop, 1 sparse random pop, 2 pop exactly on the commit edge, 3 dense random pop
  task automatic frame(input logic [7:0] b, input int hi, input int mode);
    pend_t p;
    rx_data  = b;
    rx_bussy = 1'b1;
    for (int i = 0; i < hi; i++) begin
      pop = pick_pop(mode);
      tick();
    end
    rx_bussy = 1'b0;
    p.t = cyc + 4;
    p.b = b;
    pend.push_back(p);
    for (int i = 0; i < 5; i++) begin
      pop = (mode == 2) ? (i == 3) : pick_pop(mode);
      tick();
    end
    pop = 1'b0;
  endtask

  task automatic pops(input int n);
    for (int i = 0; i < n; i++) begin
      pop = 1'b1;
      tick();
    end
    pop = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
  endtask

  task automatic fill8();
    for (int i = 1; i <= 8; i++)
      frame(8'(i), 3, 0);
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = '0;
    rx_bussy = 1'b0;
    pop      = 1'b0;
    tick();
    mon_en = 1;
    tick();
    rst = 1'b0;
    repeat (3) tick();

    frame(8'h41, 4, 0);
    tick();
    pops(1);
    tick();

    fill8();
    pops(9);

    fill8();
    frame(8'hA1, 3, 0);
    frame(8'hA2, 3, 0);
    frame(8'hA3, 3, 0);
    pops(9);

    do_reset();
    fill8();
    frame(8'h99, 3, 2);
    pops(9);

    // commit coincident with a pop on an empty FIFO: only the write happens
    frame(8'h5A, 3, 2);
    pops(2);

    // reset lands while the frame is in RECV, busy still high across it
    rx_data  = 8'hEE;
    rx_bussy = 1'b1;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    rx_bussy = 1'b0;
    repeat (8) tick();
    frame(8'h77, 4, 0);
    pops(2);

    for (int i = 0; i < 80; i++)
      frame(8'($urandom), int'($urandom_range(3, 6)), 1);
    for (int i = 0; i < 40; i++)
      frame(8'($urandom), int'($urandom_range(3, 6)), 3);
    pops(DEPTH + 1);

    do_reset();
    fill8();
    for (int i = 0; i < 300; i++)
      frame(8'($urandom), 3, 0);
    pops(DEPTH + 1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
